// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the PISO serializer.
//   piso_state_e       : frame FSM states (PARITY is only reachable with PARITY_EN)
//   PISO_WIDTH_DEFAULT : default data word width
//   PISO_CNT_W         : bit-counter width for the default word width
//   piso_cnt_w()       : bit-counter width for an arbitrary word width
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

  localparam int unsigned PISO_WIDTH_DEFAULT = 4;

  function automatic int unsigned piso_cnt_w(input int unsigned w);
    return $clog2(w);
  endfunction

  localparam int unsigned PISO_CNT_W = $clog2(PISO_WIDTH_DEFAULT);

endpackage

// File: rtl/piso_parity.sv
// piso_parity: even parity (XOR reduction) of the latched transmit word.
// Ports:
//   word   in  WIDTH  latched word
//   parity out 1      XOR of all bits of word
module piso_parity #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  output logic             parity
);

  always_comb begin
    parity = ^word;
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter, LSB first.
// A word is accepted on load_valid && load_ready and shifted out one bit per
// clock. At the final data bit load_ready is raised so back-to-back words
// stream with no idle gap.
// Optional feature macro: PARITY_EN -- appends one even-parity bit per frame
// (PARITY state); the back-to-back load is then accepted in the parity cycle.
// Ports:
//   clk         in   1      rising-edge clock
//   clr         in   1      asynchronous active-high reset
//   din         in   WIDTH  parallel word, sampled only on load accept
//   load_valid  in   1      producer presents din
//   load_ready  out  1      a word can be accepted this cycle
//   sout        out  1      serial data bit
//   sout_valid  out  1      sout carries a valid bit
//   sout_last   out  1      final bit of the frame
//   busy        out  1      a frame is in progress
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH == PISO_WIDTH_DEFAULT) ? PISO_CNT_W
                                                                : piso_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_ready_q, load_ready_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sout_last_q, sout_last_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             last_bit_d;

`ifdef PARITY_EN
  logic [WIDTH-1:0] word_q, word_d;
  logic             parity_d;

  piso_parity #(
    .WIDTH (WIDTH)
  ) u_parity (
    .word   (word_d),
    .parity (parity_d)
  );
`endif

  // Next-state logic. Outputs are derived from the next-state values and
  // registered, so they change only at clock edges and never follow
  // load_valid/din combinationally.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    accept  = load_valid && load_ready_q;
`ifdef PARITY_EN
    // accept only occurs where a (re)load happens, so latch din on accept.
    word_d  = accept ? din : word_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = din;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
`ifdef PARITY_EN
          state_d = PARITY;
`else
          if (accept) begin
            shreg_d = din;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = din;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase

    last_bit_d   = (state_d == SHIFT) && (cnt_d == LAST_CNT);
    busy_d       = (state_d != IDLE);
    sout_valid_d = (state_d != IDLE);

    case (state_d)
      SHIFT:   sout_d = shreg_d[0];
`ifdef PARITY_EN
      PARITY:  sout_d = parity_d;
`endif
      default: sout_d = 1'b0;
    endcase

`ifdef PARITY_EN
    sout_last_d  = (state_d == PARITY);
    load_ready_d = (state_d == IDLE) || (state_d == PARITY);
`else
    sout_last_d  = last_bit_d;
    load_ready_d = (state_d == IDLE) || last_bit_d;
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b1;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PARITY_EN
      word_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      load_ready_q <= load_ready_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
      busy_q       <= busy_d;
`ifdef PARITY_EN
      word_q       <= word_d;
`endif
    end
  end

  assign load_ready = load_ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed self-checking bench for piso_serializer.
// Observed vector per cycle: {sout, sout_valid, sout_last, busy, load_ready}.
module tb_piso_serializer;

  logic       clk;
  logic       clr;
  logic [3:0] din;
  logic       load_valid;
  logic       load_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_last;
  logic       busy;
  logic [3:0] cap;
  logic [4:0] obs;

  int unsigned n_pass;
  int unsigned n_total;

  piso_serializer #(
    .WIDTH (4)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {sout, sout_valid, sout_last, busy, load_ready};

  // External 4-bit SIPO capture register: MSB-side insertion, right shift.
  always @(posedge clk or posedge clr) begin
    if (clr) cap <= 4'b0000;
    else if (sout_valid) cap <= {sout, cap[3:1]};
  end

  task automatic test_reset();
    #3;
    n_total++;
    if (obs !== 5'b00001) $display("FAIL reset_async: got %b want %b", obs, 5'b00001);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (obs !== 5'b00001) $display("FAIL reset_held: got %b want %b", obs, 5'b00001);
    else n_pass++;
    @(negedge clk);
    clr = 1'b0;
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [9:0] seq;
    logic [4:0] exp;
    logic       fin;
    seq = {1'b0, 4'h5, 1'b1, 4'h7};
    din = 4'b0111;
    load_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      fin = (i == 4) || (i == 9);
      exp = {seq[i], 1'b1, fin, 1'b1, fin};
      n_total++;
      if (obs !== exp) $display("FAIL parity cyc %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      if (i == 0) din = 4'b0101;
      if (i == 5) load_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_total++;
    if (obs !== 5'b00001) $display("FAIL parity_idle: got %b want %b", obs, 5'b00001);
    else n_pass++;
  endtask
`else
  task automatic test_single_frame();
    logic [3:0] w;
    logic [4:0] exp;
    logic       fin;
    w = 4'b1011;
    din = w;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fin = (i == 3);
      exp = {w[i], 1'b1, fin, 1'b1, fin};
      n_total++;
      if (obs !== exp) $display("FAIL single_frame bit %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (obs !== 5'b00001) $display("FAIL single_frame_idle: got %b want %b", obs, 5'b00001);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    logic [4:0] exp;
    logic       fin;
    seq = {4'h5, 4'hA};
    din = 4'hA;
    load_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      fin = (i == 3) || (i == 7);
      exp = {seq[i], 1'b1, fin, 1'b1, fin};
      n_total++;
      if (obs !== exp) $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      if (i == 0) din = 4'h5;
      if (i == 4) load_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_total++;
    if (obs !== 5'b00001) $display("FAIL back_to_back_idle: got %b want %b", obs, 5'b00001);
    else n_pass++;
  endtask

  task automatic test_blocked_load();
    logic [7:0] seq;
    logic [4:0] exp;
    logic       fin;
    seq = {4'hF, 4'h3};
    din = 4'h3;
    load_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      fin = (i == 3) || (i == 7);
      exp = {seq[i], 1'b1, fin, 1'b1, fin};
      n_total++;
      if (obs !== exp) $display("FAIL blocked_load cyc %0d: got %b want %b", i, obs, exp);
      else n_pass++;
      if (i == 0) din = 4'hF;
      if (i == 4) load_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_total++;
    if (obs !== 5'b00001) $display("FAIL blocked_load_idle: got %b want %b", obs, 5'b00001);
    else n_pass++;
  endtask

  task automatic test_loopback();
    din = 4'b0110;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (cap !== 4'b0110) $display("FAIL loopback_capture: got %b want %b", cap, 4'b0110);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic saw_last;
    saw_last = 1'b0;
    din = 4'b1100;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Third bit (din[2] = 1) is on the line when clr hits.
    n_total++;
    if (obs !== 5'b11010) $display("FAIL midframe_pre: got %b want %b", obs, 5'b11010);
    else n_pass++;
    clr = 1'b1;
    load_valid = 1'b1;
    din = 4'hF;
    #1;
    n_total++;
    if (obs !== 5'b00001) $display("FAIL midframe_async: got %b want %b", obs, 5'b00001);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (sout_last) saw_last = 1'b1;
    end
    @(negedge clk);
    clr = 1'b0;
    load_valid = 1'b0;
    @(posedge clk); #1;
    if (sout_last) saw_last = 1'b1;
    n_total++;
    if (obs !== 5'b00001) $display("FAIL midframe_after: got %b want %b", obs, 5'b00001);
    else n_pass++;
    n_total++;
    if (saw_last !== 1'b0) $display("FAIL midframe_no_last: got %b want %b", saw_last, 1'b0);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass     = 0;
    n_total    = 0;
    clr        = 1'b1;
    din        = 4'h0;
    load_valid = 1'b0;
    test_reset();
`ifdef PARITY_EN
    test_parity();
`else
    test_single_frame();
    test_back_to_back();
    test_blocked_load();
    test_loopback();
    test_reset_midframe();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
